full_adder_struct_reg: RTL and testbench

FULL_ADDER_STRUCT_REG -- requirements
Module: full_adder_struct

---
 rtl/full_adder_struct_reg.sv | 106 ++++++++++
 tb/tb_full_adder_struct_reg.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_struct_reg.sv
// Structural full adder with registered result, valid flag and
// saturating operation / carry statistics counters.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_adder_struct_reg #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic p;
  logic g1;
  logic g2;

  half_adder u_ha1 (
    .x (a),
    .y (b),
    .s (p),
    .c (g1)
  );

  half_adder u_ha2 (
    .x (p),
    .y (cin),
    .s (sum),
    .c (g2)
  );

  assign cout = g1 | g2;

  // Reset asserts at once; release is seen only after two clk edges.
  logic rst_s1;
  logic rst_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_s1 <= 1'b0;
      rst_s2 <= 1'b0;
    end else begin
      rst_s1 <= 1'b1;
      rst_s2 <= rst_s1;
    end
  end

  logic accept;
  logic op_sat;
  logic carry_sat;

  assign accept    = in_valid & rst_s2;
  assign op_sat    = (op_count == CNT_MAX);
  assign carry_sat = (carry_count == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= 1'b0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        sum_q  <= sum;
        cout_q <= cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= '0;
      carry_count <= '0;
    end else if (accept) begin
      if (!op_sat) begin
        op_count <= op_count + 1'b1;
      end
      if (cout && !carry_sat) begin
        carry_count <= carry_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_struct_reg.sv
// Directed bench: scoreboard of expected registered results,
// arithmetic reference model, two counter widths.

module tb_full_adder_struct_reg;

  typedef struct packed {
    logic s;
    logic c;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic a;
  logic b;
  logic cin;
  logic in_valid;

  logic       sum8, cout8, sq8, cq8, ov8;
  logic [7:0] opc8, cc8;
  logic       sum2, cout2, sq2, cq2, ov2;
  logic [1:0] opc2, cc2;

  int checks   = 0;
  int failures = 0;

  res_t sb[$];
  int   op8_m, cc8_m, op2_m, cc2_m;
  logic sq_m, cq_m;
  int   rel;

  always #5 clk = ~clk;

  full_adder_struct_reg #(.CNT_W(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .in_valid    (in_valid),
    .sum         (sum8),
    .cout        (cout8),
    .sum_q       (sq8),
    .cout_q      (cq8),
    .out_valid   (ov8),
    .op_count    (opc8),
    .carry_count (cc8)
  );

  full_adder_struct_reg #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .in_valid    (in_valid),
    .sum         (sum2),
    .cout        (cout2),
    .sum_q       (sq2),
    .cout_q      (cq2),
    .out_valid   (ov2),
    .op_count    (opc2),
    .carry_count (cc2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic res_t ref_add(input logic x, y, z);
    int n;
    res_t r;
    n   = int'(x) + int'(y) + int'(z);
    r.s = n[0];
    r.c = (n >= 2);
    return r;
  endfunction

  task automatic chk_comb(input string tag);
    res_t r;
    r = ref_add(a, b, cin);
    chk({tag, ".sum"}, {31'd0, sum8}, {31'd0, r.s});
    chk({tag, ".cout"}, {31'd0, cout8}, {31'd0, r.c});
    chk({tag, ".sum2"}, {31'd0, sum2}, {31'd0, r.s});
    chk({tag, ".cout2"}, {31'd0, cout2}, {31'd0, r.c});
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".sum_q"}, {31'd0, sq8}, {31'd0, sq_m});
    chk({tag, ".cout_q"}, {31'd0, cq8}, {31'd0, cq_m});
    chk({tag, ".sum_q2"}, {31'd0, sq2}, {31'd0, sq_m});
    chk({tag, ".cout_q2"}, {31'd0, cq2}, {31'd0, cq_m});
    chk({tag, ".op8"}, {24'd0, opc8}, op8_m);
    chk({tag, ".cc8"}, {24'd0, cc8}, cc8_m);
    chk({tag, ".op2"}, {30'd0, opc2}, op2_m);
    chk({tag, ".cc2"}, {30'd0, cc2}, cc2_m);
  endtask

  // One clock: inputs already driven; check comb, clock, check regs.
  task automatic cycle(input string tag);
    logic acc;
    res_t r;
    res_t got;
    #1;
    chk_comb(tag);
    acc = in_valid && rst_n && (rel >= 2);
    if (acc) begin
      r = ref_add(a, b, cin);
      sb.push_back(r);
      if (op8_m < 255) op8_m++;
      if (op2_m < 3) op2_m++;
      if (r.c && cc8_m < 255) cc8_m++;
      if (r.c && cc2_m < 3) cc2_m++;
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (rel < 2) rel++;
    end else begin
      rel = 0;
    end
    chk({tag, ".out_valid"}, {31'd0, ov8}, {31'd0, acc});
    chk({tag, ".out_valid2"}, {31'd0, ov2}, {31'd0, acc});
    if (ov8) begin
      if (sb.size() > 0) begin
        got  = sb.pop_front();
        sq_m = got.s;
        cq_m = got.c;
      end else begin
        chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end
    end
    chk_regs(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    op8_m = 0;
    cc8_m = 0;
    op2_m = 0;
    cc2_m = 0;
    sq_m  = 1'b0;
    cq_m  = 1'b0;
    rel   = 0;
  endtask

  task automatic drive(input logic v, input logic [2:0] abc);
    in_valid = v;
    a        = abc[2];
    b        = abc[1];
    cin      = abc[0];
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    drive(1'b0, 3'b000);
    for (int i = 0; i < 3; i++) cycle("release");
  endtask

  initial begin
    logic [2:0] v;
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'b000);
    #1;
    chk({"reset0", ".out_valid"}, {31'd0, ov8}, 32'd0);
    chk_regs("reset0");
    chk_comb("reset0");

    // In_valid ignored while held in reset.
    drive(1'b1, 3'b111);
    cycle("in_reset0");
    cycle("in_reset1");

    // Release with valid high: first two edges must not accept.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("sync_rel");

    model_reset();
    rst_n = 1'b0;
    #1;
    chk_regs("reset1");
    @(posedge clk);
    #1;
    release_reset();

    // Combinational sweep, no acceptance.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(1'b0, v);
      cycle("sweep");
    end

    // Single 1+1+1 operation then idle.
    drive(1'b1, 3'b111);
    cycle("single");
    chk("single.sum_q_is1", {31'd0, sq8}, 32'd1);
    chk("single.op_is1", {24'd0, opc8}, 32'd1);
    drive(1'b0, 3'b000);
    cycle("single_idle");

    // Back-to-back over all combinations.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(1'b1, v);
      cycle("b2b");
    end
    drive(1'b0, 3'b000);
    cycle("b2b_tail");
    chk("b2b.op_total", {24'd0, opc8}, 32'd9);
    chk("b2b.cc_total", {24'd0, cc8}, 32'd5);

    // Inputs toggle without valid.
    for (int i = 0; i < 5; i++) begin
      v = 3'($urandom_range(7));
      drive(1'b0, v);
      cycle("idle_toggle");
    end

    // Mid-stream asynchronous reset.
    drive(1'b1, 3'b110);
    cycle("stream0");
    drive(1'b1, 3'b011);
    cycle("stream1");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.out_valid", {31'd0, ov8}, 32'd0);
    chk_regs("midrst");
    chk_comb("midrst");
    drive(1'b1, 3'b100);
    #1;
    chk_comb("midrst_track");
    cycle("midrst_hold");
    release_reset();

    // Saturation of the narrow counters.
    for (int i = 0; i < 6; i++) begin
      v = {2'b11, 1'($urandom_range(1))};
      drive(1'b1, v);
      cycle("sat2");
    end
    chk("sat2.op", {30'd0, opc2}, 32'd3);
    chk("sat2.cc", {30'd0, cc2}, 32'd3);

    // Saturation of the wide counters.
    for (int i = 0; i < 260; i++) begin
      v = 3'($urandom_range(7));
      drive(1'b1, v);
      cycle("sat8");
    end
    drive(1'b0, 3'b000);
    cycle("sat8_tail");
    chk("sat8.op", {24'd0, opc8}, 32'd255);
    chk("sat8.cc_le_op", {31'd0, (cc8 <= opc8)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
